imem_slave: RTL

AXI-lite responder that serves the instruction fetch stage's read requests from an on-chip word-addressed instruction memory. Sits on the far side of the `axi_lite_if` that fetch drives as master: accepts AR requests, returns 32-bit instruction words with AXI response codes, and optionally accepts writes for program loading. Sustains one read per cycle with one-cycle latency.

---
 rtl/imem_slave_if.sv | 34 +++
 rtl/imem_slave.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/imem_slave_if.sv
// AXI-lite channel bundle shared by the fetch master and the instruction memory.
// M is the requester side, S the responder side.
interface axi_lite_if #(
   parameter int XLEN = 64
);
   logic            arvalid;
   logic            arready;
   logic [XLEN-1:0] araddr;
   logic [2:0]      arprot;
   logic            rvalid;
   logic            rready;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic            awvalid;
   logic            awready;
   logic [XLEN-1:0] awaddr;
   logic            wvalid;
   logic            wready;
   logic [31:0]     wdata;
   logic [3:0]      wstrb;
   logic            bvalid;
   logic            bready;
   logic [1:0]      bresp;

   modport M (
      output arvalid, araddr, arprot, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
      input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
   );

   modport S (
      input  arvalid, araddr, arprot, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
      output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
   );
endinterface

// File: rtl/imem_slave.sv
// AXI-lite instruction memory responder; writes update memory only when IMEM_WRITE_EN is defined.
// Latency: AR handshake -> R beat next cycle; AW+W both held -> commit and B beat next cycle.
// Backpressure: arready drops while an R beat is stalled; AW/W held until B handshake.
module imem_slave #(
   parameter int              XLEN      = 64,
   parameter int              DEPTH     = 1024,
   parameter logic [XLEN-1:0] BASE_ADDR = '0,
   parameter string           INIT_FILE = ""
) (
   input logic    clk,
   input logic    rst,
   axi_lite_if.S  is_if
);

   localparam int              IDX_W  = $clog2(DEPTH);
   localparam logic [XLEN-1:0] SPAN   = XLEN'(DEPTH) << 2;
   localparam logic [1:0]      OKAY   = 2'b00;
   localparam logic [1:0]      SLVERR = 2'b10;
   localparam logic [1:0]      DECERR = 2'b11;

   // Out-of-range beats misalignment; the subtraction wraps below BASE_ADDR, hence the explicit compare.
   function automatic logic [1:0] decode(input logic [XLEN-1:0] addr);
      logic [XLEN-1:0] off;
      off = addr - BASE_ADDR;
      if (addr < BASE_ADDR || off >= SPAN)
         decode = DECERR;
      else if (addr[1:0] != 2'b00)
         decode = SLVERR;
      else
         decode = OKAY;
   endfunction

   function automatic logic [IDX_W-1:0] word_index(input logic [XLEN-1:0] addr);
      word_index = IDX_W'((addr - BASE_ADDR) >> 2);
   endfunction

   logic [31:0] mem [DEPTH];

   logic             rvalid;
   logic [31:0]      rdata;
   logic [1:0]       rresp;
   logic             ar_hs;
   logic [1:0]       ar_resp;
   logic [IDX_W-1:0] ar_idx;

   assign ar_resp        = decode(is_if.araddr);
   assign ar_idx         = word_index(is_if.araddr);
   assign is_if.arready  = !rvalid || is_if.rready;
   assign ar_hs          = is_if.arvalid && is_if.arready;
   assign is_if.rvalid   = rvalid;
   assign is_if.rdata    = rdata;
   assign is_if.rresp    = rresp;

   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid <= 1'b0;
         rdata  <= '0;
         rresp  <= OKAY;
      end else if (ar_hs) begin
         rvalid <= 1'b1;
         rresp  <= ar_resp;
         rdata  <= (ar_resp == OKAY) ? mem[ar_idx] : '0;
      end else if (is_if.rready) begin
         rvalid <= 1'b0;
      end
   end

   logic            aw_held;
   logic            w_held;
   logic            bvalid;
   logic [1:0]      bresp;
   logic [XLEN-1:0] awaddr_q;
   logic [31:0]     wdata_q;
   logic [3:0]      wstrb_q;
   logic            aw_hs;
   logic            w_hs;
   logic            commit;
   logic [1:0]      wr_dec;
   logic [1:0]      wr_resp;

   assign is_if.awready = !aw_held && !bvalid;
   assign is_if.wready  = !w_held && !bvalid;
   assign is_if.bvalid  = bvalid;
   assign is_if.bresp   = bresp;
   assign aw_hs         = is_if.awvalid && is_if.awready;
   assign w_hs          = is_if.wvalid && is_if.wready;
   assign commit        = aw_held && w_held;
   assign wr_dec        = decode(awaddr_q);

`ifdef IMEM_WRITE_EN
   assign wr_resp = wr_dec;
`else
   // Read-only image: in-range writes are refused rather than decoded as absent.
   assign wr_resp = (wr_dec == DECERR) ? DECERR : SLVERR;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         bvalid  <= 1'b0;
         bresp   <= OKAY;
      end else begin
         if (aw_hs) aw_held <= 1'b1;
         if (w_hs)  w_held  <= 1'b1;
         if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= wr_resp;
         end else if (is_if.bready) begin
            bvalid  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (aw_hs) awaddr_q <= is_if.awaddr;
      if (w_hs) begin
         wdata_q <= is_if.wdata;
         wstrb_q <= is_if.wstrb;
      end
   end

`ifdef IMEM_WRITE_EN
   logic [IDX_W-1:0] wr_idx;
   assign wr_idx = word_index(awaddr_q);

   always_ff @(posedge clk) begin
      if (!rst && commit && wr_dec == OKAY) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) mem[wr_idx][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end
`else
   logic unused_wr;
   assign unused_wr = ^{wdata_q, wstrb_q};
`endif

   logic unused_ar;
   assign unused_ar = ^is_if.arprot;

endmodule
